// File: rtl/hex_scan_pkg.sv
// Shared definitions for the hex scan display driver.
//   scan_state_t : scan FSM state (BLANK gap, then DRIVE one digit)
//   SEG_BLANK    : active-low segment pattern with every segment off
//   seg7_hex     : hex nibble to active-low {g,f,e,d,c,b,a} pattern
package hex_scan_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble : 4-bit hex digit
//   seg    : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
    import hex_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg7_hex(nibble);

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. CPU writes land in a
// shadow register and are committed to the displayed value only at a frame
// boundary, so a frame never mixes old and new digits. Each digit slot opens
// with a blanking gap (all anodes off) to suppress ghosting.
//
// Ports:
//   clck           : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   data_in        : value written by the CPU (4 bits per digit)
//   data_valid     : one-cycle write strobe for data_in
//   seg_n          : active-low segments {g,f,e,d,c,b,a}, registered
//   an_n           : active-low digit anodes, at most one low, registered
//   update_pending : shadow holds a value not yet committed
//
// Build option: define HEX_SCAN_LZB_EN to blank leading zeros (digit 0 is
// always shown; blanked digits keep their anode timing).
module hex_scan_driver
    import hex_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clck,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    data_valid,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    update_pending
);

    localparam int unsigned DataW = 4 * NUM_DIGITS;
    localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DigW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    scan_state_t           state_q, state_d;
    logic [CntW-1:0]       div_cnt_q, div_cnt_d;
    logic [DigW-1:0]       digit_q, digit_d;
    logic [DataW-1:0]      shadow_q, shadow_d;
    logic [DataW-1:0]      active_q, active_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [3:0]            nibble;
    logic [6:0]            seg_dec;
    logic                  lz_blank;

    assign slot_end  = (div_cnt_q == CntW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (digit_q == DigW'(NUM_DIGITS - 1));

    // Digit select and nibble mux. Using the current digit/active values is
    // safe: both only change on a slot wrap, which always lands in BLANK.
    always_comb begin
        digit_sel = '0;
        nibble    = 4'h0;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            digit_sel[d] = (digit_q == DigW'(d));
            if (digit_sel[d]) begin
                nibble = active_q[4*d +: 4];
            end
        end
    end

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

`ifdef HEX_SCAN_LZB_EN
    // Walk down from the top digit; a digit is blanked while it and every
    // higher nibble are zero. Digit 0 is never considered.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = 1'b0;
        for (int d = int'(NUM_DIGITS) - 1; d >= 1; d--) begin
            zero_above = zero_above && (active_q[4*d +: 4] == 4'h0);
            if (digit_sel[d] && zero_above) begin
                lz_blank = 1'b1;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Slot counter, digit index and shadow/active commit.
    always_comb begin
        div_cnt_d = slot_end ? '0 : div_cnt_q + CntW'(1);
        digit_d   = digit_q;
        if (slot_end) begin
            digit_d = (digit_q == DigW'(NUM_DIGITS - 1)) ? '0 : digit_q + DigW'(1);
        end

        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (data_valid) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end
        if (frame_end) begin
            // A write on the commit cycle bypasses the shadow so it is not
            // delayed by a whole frame.
            if (data_valid) begin
                active_d  = data_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    // Scan FSM; outputs are computed from the next state so the registered
    // outputs change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        an_n_d  = '1;
        seg_n_d = SEG_BLANK;

        unique case (state_q)
            BLANK: begin
                if (div_cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (slot_end) begin
                    state_d = BLANK;
                end
            end
            default: state_d = BLANK;
        endcase

        if (state_d == DRIVE) begin
            an_n_d  = ~digit_sel;
            seg_n_d = lz_blank ? SEG_BLANK : seg_dec;
        end
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BLANK;
            div_cnt_q <= '0;
            digit_q   <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_n_q   <= SEG_BLANK;
            an_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            digit_q   <= digit_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            seg_n_q   <= seg_n_d;
            an_n_q    <= an_n_d;
        end
    end

    assign seg_n          = seg_n_q;
    assign an_n           = an_n_q;
    assign update_pending = pending_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed, table-driven bench for hex_scan_driver with NUM_DIGITS=4,
// REFRESH_DIV=8, BLANK_CYCLES=2. Each record names a cycle count after reset
// release, the expected outputs there, and an optional write strobe applied
// on the following edge. Honours HEX_SCAN_LZB_EN for leading-zero digits.
module tb_hex_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;

`ifdef HEX_SCAN_LZB_EN
    localparam logic [6:0] ZL = 7'h7F;
`else
    localparam logic [6:0] ZL = 7'h40;
`endif

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] wdata;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        pend;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_valid;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        update_pending;

    int checks;
    int failures;
    int k;

    vec_t tab_a[$];
    vec_t tab_b[$];

    hex_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clck           (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .seg_n          (seg_n),
        .an_n           (an_n),
        .update_pending (update_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int cyc, input logic wr, input logic [15:0] wdata,
                                input logic [3:0] an, input logic [6:0] seg, input logic pend);
        vec_t v;
        v.cyc   = cyc;
        v.wr    = wr;
        v.wdata = wdata;
        v.an    = an;
        v.seg   = seg;
        v.pend  = pend;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at k=%0d t=%0t: got %h, want %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic apply(input vec_t v);
        while (k < v.cyc) step();
        check("an_n", 16'(an_n), 16'(v.an));
        check("seg_n", 16'(seg_n), 16'(v.seg));
        check("update_pending", 16'(update_pending), 16'(v.pend));
        if (v.wr) begin
            data_valid = 1'b1;
            data_in    = v.wdata;
            step();
            data_valid = 1'b0;
            data_in    = 16'h0;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        k          = 0;
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_in    = 16'h0;

        // Power-up scan of an all-zero value, mid-frame write of 1A2F.
        tab_a.push_back(mk(0,   0, 16'h0,    4'hF, 7'h7F, 0));
        tab_a.push_back(mk(1,   0, 16'h0,    4'hF, 7'h7F, 0));
        tab_a.push_back(mk(2,   0, 16'h0,    4'hE, 7'h40, 0));
        tab_a.push_back(mk(7,   0, 16'h0,    4'hE, 7'h40, 0));
        tab_a.push_back(mk(8,   0, 16'h0,    4'hF, 7'h7F, 0));
        tab_a.push_back(mk(9,   0, 16'h0,    4'hF, 7'h7F, 0));
        tab_a.push_back(mk(10,  0, 16'h0,    4'hD, ZL,    0));
        tab_a.push_back(mk(12,  1, 16'h1A2F, 4'hD, ZL,    0));
        tab_a.push_back(mk(13,  0, 16'h0,    4'hD, ZL,    1));
        tab_a.push_back(mk(18,  0, 16'h0,    4'hB, ZL,    1));
        tab_a.push_back(mk(20,  0, 16'h0,    4'hB, ZL,    1));
        tab_a.push_back(mk(26,  0, 16'h0,    4'h7, ZL,    1));
        tab_a.push_back(mk(31,  0, 16'h0,    4'h7, ZL,    1));
        tab_a.push_back(mk(32,  0, 16'h0,    4'hF, 7'h7F, 0));
        // Frame 1 shows 1A2F; two writes, last one (2222) wins.
        tab_a.push_back(mk(34,  0, 16'h0,    4'hE, 7'h0E, 0));
        tab_a.push_back(mk(36,  1, 16'h1111, 4'hE, 7'h0E, 0));
        tab_a.push_back(mk(37,  0, 16'h0,    4'hE, 7'h0E, 1));
        tab_a.push_back(mk(40,  1, 16'h2222, 4'hF, 7'h7F, 1));
        tab_a.push_back(mk(41,  0, 16'h0,    4'hF, 7'h7F, 1));
        tab_a.push_back(mk(42,  0, 16'h0,    4'hD, 7'h24, 1));
        tab_a.push_back(mk(50,  0, 16'h0,    4'hB, 7'h08, 1));
        tab_a.push_back(mk(58,  0, 16'h0,    4'h7, 7'h79, 1));
        tab_a.push_back(mk(63,  0, 16'h0,    4'h7, 7'h79, 1));
        tab_a.push_back(mk(64,  0, 16'h0,    4'hF, 7'h7F, 0));
        tab_a.push_back(mk(66,  0, 16'h0,    4'hE, 7'h24, 0));
        tab_a.push_back(mk(74,  0, 16'h0,    4'hD, 7'h24, 0));
        tab_a.push_back(mk(82,  0, 16'h0,    4'hB, 7'h24, 0));
        tab_a.push_back(mk(90,  0, 16'h0,    4'h7, 7'h24, 0));
        // Write 0009 sampled on the commit edge: bypass, no pending.
        tab_a.push_back(mk(95,  1, 16'h0009, 4'h7, 7'h24, 0));
        tab_a.push_back(mk(96,  0, 16'h0,    4'hF, 7'h7F, 0));
        tab_a.push_back(mk(97,  0, 16'h0,    4'hF, 7'h7F, 0));
        tab_a.push_back(mk(98,  0, 16'h0,    4'hE, 7'h10, 0));
        tab_a.push_back(mk(100, 0, 16'h0,    4'hE, 7'h10, 0));
        tab_a.push_back(mk(106, 1, 16'hBEEF, 4'hD, ZL,    0));
        tab_a.push_back(mk(107, 0, 16'h0,    4'hD, ZL,    1));

        // After mid-frame reset: active is 0, then 0050 is committed.
        tab_b.push_back(mk(0,  0, 16'h0,    4'hF, 7'h7F, 0));
        tab_b.push_back(mk(2,  0, 16'h0,    4'hE, 7'h40, 0));
        tab_b.push_back(mk(5,  1, 16'h0050, 4'hE, 7'h40, 0));
        tab_b.push_back(mk(6,  0, 16'h0,    4'hE, 7'h40, 1));
        tab_b.push_back(mk(10, 0, 16'h0,    4'hD, ZL,    1));
        tab_b.push_back(mk(31, 0, 16'h0,    4'h7, ZL,    1));
        tab_b.push_back(mk(32, 0, 16'h0,    4'hF, 7'h7F, 0));
        tab_b.push_back(mk(34, 0, 16'h0,    4'hE, 7'h40, 0));
        tab_b.push_back(mk(42, 0, 16'h0,    4'hD, 7'h12, 0));
        tab_b.push_back(mk(50, 0, 16'h0,    4'hB, ZL,    0));
        tab_b.push_back(mk(58, 0, 16'h0,    4'h7, ZL,    0));

        // Outputs held in reset while the clock runs.
        repeat (3) @(posedge clk);
        #1;
        check("reset an_n", 16'(an_n), 16'hF);
        check("reset seg_n", 16'(seg_n), 16'h7F);
        check("reset update_pending", 16'(update_pending), 16'h0);
        rst_n = 1'b1;
        k     = 0;

        foreach (tab_a[i]) apply(tab_a[i]);

        // Mid-DRIVE reset (digit 1 lit, write pending): outputs drop before
        // any further clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async an_n", 16'(an_n), 16'hF);
        check("async seg_n", 16'(seg_n), 16'h7F);
        check("async update_pending", 16'(update_pending), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        k     = 0;

        foreach (tab_b[i]) apply(tab_b[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
